datapath_regfile: RTL and testbench

DATAPATH_REGFILE -- requirements
Module: datapath_regfile

---
 rtl/datapath_regfile_if.sv | 33 +++
 rtl/datapath_regfile.sv | 149 ++++++++++++++
 tb/tb_datapath_regfile.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/datapath_regfile_if.sv
// Datapath register-file bus: C-bus write side, B-bus/H read side, memory and fetch ports.
interface datapath_regfile_if;
  logic [31:0] Shift;
  logic [8:0]  C_SEL;
  logic [3:0]  B_SEL;
  logic [2:0]  MEM_CTL;
  logic [31:0] B_bus;
  logic [31:0] H_out;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic        MEM_RD;
  logic        MEM_WR;
  logic [31:0] MEM_RDATA;
  logic        MEM_RVALID;
  logic [31:0] FETCH_ADDR;
  logic        FETCH_RD;
  logic [7:0]  FETCH_DATA;
  logic        FETCH_VALID;
  logic        BUSY;
  logic        REQ_ERR;

  modport master (
    output Shift, C_SEL, B_SEL, MEM_CTL, MEM_RDATA, MEM_RVALID, FETCH_DATA, FETCH_VALID,
    input  B_bus, H_out, MEM_ADDR, MEM_WDATA, MEM_RD, MEM_WR, FETCH_ADDR, FETCH_RD,
           BUSY, REQ_ERR
  );

  modport slave (
    input  Shift, C_SEL, B_SEL, MEM_CTL, MEM_RDATA, MEM_RVALID, FETCH_DATA, FETCH_VALID,
    output B_bus, H_out, MEM_ADDR, MEM_WDATA, MEM_RD, MEM_WR, FETCH_ADDR, FETCH_RD,
           BUSY, REQ_ERR
  );
endinterface

// File: rtl/datapath_regfile.sv
// Nine-register datapath file with memory-read and byte-fetch handshakes.
// Define DATAPATH_FETCH_EN to build the fetch path (FETCH_RD, MBR, F_WAIT).
//
//   state   | meaning
//   IDLE    | no memory read outstanding
//   RD_WAIT | read strobed, waiting for MEM_RVALID to load MDR
//   F_IDLE  | no fetch outstanding
//   F_WAIT  | fetch strobed, waiting for FETCH_VALID to load MBR
module datapath_regfile (
  input  logic               CLK,
  input  logic               RST,
  datapath_regfile_if.slave  bus
);
  localparam int R_MAR = 0;
  localparam int R_MDR = 1;
  localparam int R_PC  = 2;
  localparam int R_SP  = 3;
  localparam int R_LV  = 4;
  localparam int R_CPP = 5;
  localparam int R_TOS = 6;
  localparam int R_OPC = 7;
  localparam int R_H   = 8;

  typedef enum logic {IDLE,   RD_WAIT} rd_state_t;
  typedef enum logic {F_IDLE, F_WAIT}  f_state_t;

  rd_state_t   rd_state_q, rd_state_d;
  f_state_t    f_state_q,  f_state_d;
  logic [31:0] reg_q [9];
  logic [31:0] reg_d [9];
  logic [7:0]  mbr_q, mbr_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic        fetch_rd_q, fetch_rd_d;
  logic        req_err_q, req_err_d;
  logic        rd_req, wr_req;

  assign wr_req = bus.MEM_CTL[2];
  assign rd_req = bus.MEM_CTL[1];

  always_comb begin
    reg_d      = reg_q;
    mbr_d      = mbr_q;
    rd_state_d = rd_state_q;
    f_state_d  = f_state_q;
    mem_rd_d   = 1'b0;
    mem_wr_d   = 1'b0;
    fetch_rd_d = 1'b0;
    req_err_d  = req_err_q;

    for (int i = 0; i < 9; i++) begin
      if (bus.C_SEL[i]) reg_d[i] = bus.Shift;
    end

    if (rd_req && wr_req) begin
      req_err_d = 1'b1;
    end else if (wr_req) begin
      mem_wr_d = 1'b1;
    end else if (rd_req) begin
      if (rd_state_q == IDLE) begin
        mem_rd_d   = 1'b1;
        rd_state_d = RD_WAIT;
      end else begin
        req_err_d = 1'b1;
      end
    end

    // Returning read data wins over a C-bus write to MDR on the same edge.
    if (rd_state_q == RD_WAIT && bus.MEM_RVALID) begin
      reg_d[R_MDR] = bus.MEM_RDATA;
      rd_state_d   = IDLE;
    end

`ifdef DATAPATH_FETCH_EN
    if (bus.MEM_CTL[0]) begin
      if (f_state_q == F_IDLE) begin
        fetch_rd_d = 1'b1;
        f_state_d  = F_WAIT;
      end else begin
        req_err_d = 1'b1;
      end
    end
    if (f_state_q == F_WAIT && bus.FETCH_VALID) begin
      mbr_d     = bus.FETCH_DATA;
      f_state_d = F_IDLE;
    end
`else
    f_state_d = F_IDLE;
    mbr_d     = '0;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 9; i++) reg_q[i] <= '0;
      mbr_q      <= '0;
      rd_state_q <= IDLE;
      f_state_q  <= F_IDLE;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      fetch_rd_q <= 1'b0;
      req_err_q  <= 1'b0;
    end else begin
      reg_q      <= reg_d;
      mbr_q      <= mbr_d;
      rd_state_q <= rd_state_d;
      f_state_q  <= f_state_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      fetch_rd_q <= fetch_rd_d;
      req_err_q  <= req_err_d;
    end
  end

`ifndef DATAPATH_FETCH_EN
  logic unused_fetch;
  assign unused_fetch = ^{bus.MEM_CTL[0], bus.FETCH_DATA, bus.FETCH_VALID, fetch_rd_q};
`endif

  always_comb begin
    bus.B_bus = '0;
    case (bus.B_SEL)
      4'd0:    bus.B_bus = reg_q[R_MDR];
      4'd1:    bus.B_bus = reg_q[R_PC];
      4'd2:    bus.B_bus = {{24{mbr_q[7]}}, mbr_q};
      4'd3:    bus.B_bus = {24'b0, mbr_q};
      4'd4:    bus.B_bus = reg_q[R_SP];
      4'd5:    bus.B_bus = reg_q[R_LV];
      4'd6:    bus.B_bus = reg_q[R_CPP];
      4'd7:    bus.B_bus = reg_q[R_TOS];
      4'd8:    bus.B_bus = reg_q[R_OPC];
      default: bus.B_bus = '0;
    endcase
  end

  assign bus.H_out      = reg_q[R_H];
  assign bus.MEM_ADDR   = reg_q[R_MAR];
  assign bus.MEM_WDATA  = reg_q[R_MDR];
  assign bus.FETCH_ADDR = reg_q[R_PC];
  assign bus.MEM_RD     = mem_rd_q;
  assign bus.MEM_WR     = mem_wr_q;
`ifdef DATAPATH_FETCH_EN
  assign bus.FETCH_RD   = fetch_rd_q;
`else
  assign bus.FETCH_RD   = 1'b0;
`endif
  assign bus.BUSY       = (rd_state_q == RD_WAIT) || (f_state_q == F_WAIT);
  assign bus.REQ_ERR    = req_err_q;
endmodule

// File: tb/tb_datapath_regfile.sv
// Directed bench for datapath_regfile; expectations follow DATAPATH_FETCH_EN when defined.
module tb_datapath_regfile;
`ifdef DATAPATH_FETCH_EN
  localparam bit FETCH_EN = 1'b1;
`else
  localparam bit FETCH_EN = 1'b0;
`endif
  localparam logic [2:0] C_NONE  = 3'b000;
  localparam logic [2:0] C_WRITE = 3'b100;
  localparam logic [2:0] C_READ  = 3'b010;
  localparam logic [2:0] C_FETCH = 3'b001;

  logic CLK;
  logic RST;
  int   n_vec;
  int   n_err;

  datapath_regfile_if bus ();

  datapath_regfile dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic [3:0] sel, input logic [31:0] exp);
    bus.B_SEL = sel;
    #1;
    chk(tag, bus.B_bus, exp);
  endtask

  task automatic idle_inputs();
    bus.C_SEL       = '0;
    bus.MEM_CTL     = C_NONE;
    bus.MEM_RVALID  = 1'b0;
    bus.FETCH_VALID = 1'b0;
  endtask

  logic [3:0] sels [7] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};

  initial begin
    n_vec = 0;
    n_err = 0;
    RST = 1'b1;
    bus.Shift = 32'hDEAD_0000;
    bus.C_SEL = 9'h1FF;
    bus.B_SEL = '0;
    bus.MEM_CTL = C_READ;
    bus.MEM_RDATA = '0;
    bus.MEM_RVALID = 1'b0;
    bus.FETCH_DATA = '0;
    bus.FETCH_VALID = 1'b0;
    cyc();
    cyc();
    idle_inputs();
    cyc();
    RST = 1'b0;
    chk_b("rst_mdr", 4'd0, 32'h0);
    chk("rst_h", bus.H_out, 32'h0);
    chk("rst_busy", bus.BUSY, 32'h0);
    chk("rst_memrd", bus.MEM_RD, 32'h0);
    chk("rst_err", bus.REQ_ERR, 32'h0);

    // broadcast write to all nine registers
    bus.C_SEL = 9'h1FF;
    bus.Shift = 32'hDEAD_BEEF;
    cyc();
    bus.C_SEL = '0;
    foreach (sels[i]) chk_b($sformatf("bsel_%0d", sels[i]), sels[i], 32'hDEAD_BEEF);
    chk("h_out", bus.H_out, 32'hDEAD_BEEF);
    chk_b("bsel_12", 4'd12, 32'h0);
    chk_b("bsel_2_mbr0", 4'd2, 32'h0);

    // read: MAR written on the same edge as READ
    bus.C_SEL = 9'h001;
    bus.Shift = 32'h0000_0010;
    bus.MEM_CTL = C_READ;
    cyc();
    idle_inputs();
    chk("rd_strobe", bus.MEM_RD, 32'h1);
    chk("rd_addr", bus.MEM_ADDR, 32'h10);
    chk("rd_busy", bus.BUSY, 32'h1);
    cyc();
    chk("rd_strobe_once", bus.MEM_RD, 32'h0);
    bus.MEM_RVALID = 1'b1;
    bus.MEM_RDATA = 32'h1234_5678;
    cyc();
    idle_inputs();
    chk_b("rd_mdr", 4'd0, 32'h1234_5678);
    chk("rd_wdata", bus.MEM_WDATA, 32'h1234_5678);
    chk("rd_busy_fall", bus.BUSY, 32'h0);
    bus.MEM_RVALID = 1'b1;
    bus.MEM_RDATA = 32'h0000_FFFF;
    cyc();
    idle_inputs();
    chk_b("stray_rvalid", 4'd0, 32'h1234_5678);

    // write with same-cycle MDR load
    bus.C_SEL = 9'h002;
    bus.Shift = 32'hCAFE_0001;
    bus.MEM_CTL = C_WRITE;
    cyc();
    idle_inputs();
    chk("wr_strobe", bus.MEM_WR, 32'h1);
    chk("wr_data", bus.MEM_WDATA, 32'hCAFE_0001);
    chk("wr_no_rd", bus.MEM_RD, 32'h0);
    cyc();
    chk("wr_strobe_once", bus.MEM_WR, 32'h0);

    // write while read pending, then RVALID racing a C-bus MDR write
    bus.MEM_CTL = C_READ;
    cyc();
    bus.MEM_CTL = C_WRITE;
    cyc();
    idle_inputs();
    chk("wr_in_rdwait", bus.MEM_WR, 32'h1);
    chk("wr_in_rdwait_busy", bus.BUSY, 32'h1);
    chk("wr_in_rdwait_err", bus.REQ_ERR, 32'h0);
    bus.MEM_RVALID = 1'b1;
    bus.MEM_RDATA = 32'hAAAA_0000;
    bus.C_SEL = 9'h002;
    bus.Shift = 32'h0000_5555;
    cyc();
    idle_inputs();
    chk_b("rvalid_prio", 4'd0, 32'hAAAA_0000);
    chk("rvalid_prio_busy", bus.BUSY, 32'h0);

    // fetch from PC=4
    bus.C_SEL = 9'h004;
    bus.Shift = 32'h0000_0004;
    bus.MEM_CTL = C_FETCH;
    cyc();
    idle_inputs();
    chk("fetch_addr", bus.FETCH_ADDR, 32'h4);
    chk("fetch_rd", bus.FETCH_RD, FETCH_EN ? 32'h1 : 32'h0);
    chk("fetch_busy", bus.BUSY, FETCH_EN ? 32'h1 : 32'h0);
    cyc();
    chk("fetch_rd_once", bus.FETCH_RD, 32'h0);
    bus.FETCH_VALID = 1'b1;
    bus.FETCH_DATA = 8'h80;
    cyc();
    idle_inputs();
    chk_b("mbr_sext", 4'd2, FETCH_EN ? 32'hFFFF_FF80 : 32'h0);
    chk_b("mbr_zext", 4'd3, FETCH_EN ? 32'h0000_0080 : 32'h0);
    chk("fetch_busy_fall", bus.BUSY, 32'h0);
    chk("fetch_no_err", bus.REQ_ERR, 32'h0);

    // READ while RD_WAIT: dropped, sticky error
    bus.MEM_CTL = C_READ;
    cyc();
    chk("rd2_accept", bus.MEM_RD, 32'h1);
    cyc();
    idle_inputs();
    chk("rd_in_wait_nostrobe", bus.MEM_RD, 32'h0);
    chk("rd_in_wait_err", bus.REQ_ERR, 32'h1);
    cyc();
    cyc();
    cyc();
    chk("err_sticky", bus.REQ_ERR, 32'h1);
    chk("still_busy", bus.BUSY, 32'h1);

    // reset mid-read, then a late RVALID
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    chk("rst_mid_busy", bus.BUSY, 32'h0);
    chk("rst_mid_err", bus.REQ_ERR, 32'h0);
    bus.MEM_RVALID = 1'b1;
    bus.MEM_RDATA = 32'h0000_0077;
    cyc();
    idle_inputs();
    chk_b("late_rvalid_mdr", 4'd0, 32'h0);
    chk("late_rvalid_busy", bus.BUSY, 32'h0);
    chk("late_rvalid_err", bus.REQ_ERR, 32'h0);

    // READ + WRITE together
    bus.MEM_CTL = C_READ | C_WRITE;
    cyc();
    idle_inputs();
    chk("rw_no_rd", bus.MEM_RD, 32'h0);
    chk("rw_no_wr", bus.MEM_WR, 32'h0);
    chk("rw_err", bus.REQ_ERR, 32'h1);
    chk("rw_not_busy", bus.BUSY, 32'h0);
    cyc();
    cyc();
    chk("rw_err_held", bus.REQ_ERR, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
